// File: rtl/prog_loader.sv
// Boot-time program loader: arms on a sync byte, packs UART bytes big-endian into 32-bit words,
// writes them to instruction memory until an all-zero terminator, then acknowledges over UART.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter logic [7:0]  ACK_BYTE  = 8'h55
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  input  logic              rx_ferr_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  typedef enum logic [2:0] {StIdle, StRecv, StWrite, StAck, StDone, StErr} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              take_byte;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      byte_idx_q <= '0;
      shift_q    <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    take_byte  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_ready_i && !rx_ferr_i && rx_data_i == SYNC_BYTE) state_d = StRecv;
      end
      StRecv: take_byte = 1'b1;
      StWrite: begin
        count_d = count_q + 1'b1;
        if (wdata_q == '0) begin
          state_d = StAck;
        end else if (addr_q == LastAddr) begin
          state_d = StErr;
        end else begin
          addr_d    = addr_q + 1'b1;
          state_d   = StRecv;
          // A byte landing in this cycle already belongs to the next word.
          take_byte = 1'b1;
        end
      end
      StAck: begin
        if (!tx_busy_i) begin
          tx_start_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          state_d    = StDone;
        end
      end
      StDone, StErr: ;
      default: state_d = StIdle;
    endcase

    if (take_byte && rx_ready_i) begin
      if (rx_ferr_i) begin
        state_d = StErr;
      end else begin
        // Lane index 8*(3-idx): first byte lands in [31:24].
        shift_d[{~byte_idx_q, 3'b000} +: 8] = rx_data_i;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          wdata_d = {shift_q[31:8], rx_data_i};
          state_d = StWrite;
        end
      end
    end
  end

  assign imem_we_o    = (state_q == StWrite);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign word_count_o = count_q;
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign load_done_o  = (state_q == StDone);
  assign load_err_o   = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a byte/word-level reference model predicts every output each
// cycle, and directed scenarios pin the model with literal expectations.
module tb_prog_loader;

  localparam int unsigned AW    = 2;
  localparam int          Depth = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          rx_ferr = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          load_done;
  logic          load_err;

  bit            rand_busy = 1'b0;
  bit            busy_force = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  prog_loader #(
    .ADDR_W   (AW),
    .SYNC_BYTE(8'hAA),
    .ACK_BYTE (8'h55)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data_i   (rx_data),
    .rx_ready_i  (rx_ready),
    .rx_ferr_i   (rx_ferr),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_busy_i   (tx_busy),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .word_count_o(word_count),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) tx_busy = rand_busy ? 1'($urandom_range(0, 1)) : busy_force;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the load as "synced / receiving / words written / ack owed".
  bit         started = 1'b0;
  bit         m_synced, m_rxon, m_wpend, m_ack, m_done, m_err, m_sent;
  int         m_words;
  logic [31:0] m_word;
  logic [7:0] m_buf[$];
  bit         e_we, e_tx_start;
  logic [31:0] e_addr, e_wdata;

  always @(posedge clk) begin
    started = 1'b1;
    e_we = 1'b0;
    e_tx_start = 1'b0;
    if (!rstn) begin
      {m_synced, m_rxon, m_wpend, m_ack, m_done, m_err, m_sent} = '0;
      m_words = 0;
      m_buf.delete();
    end else begin
      if (m_ack && !tx_busy) begin
        m_ack = 1'b0; m_done = 1'b1; m_sent = 1'b1; e_tx_start = 1'b1;
      end
      if (m_wpend) begin
        m_wpend = 1'b0;
        m_words++;
        if (m_word == 0) begin
          m_ack = 1'b1; m_rxon = 1'b0;
        end else if (m_words == Depth) begin
          m_err = 1'b1; m_rxon = 1'b0;
        end
      end
      if (rx_ready) begin
        if (!m_synced) begin
          if (!rx_ferr && rx_data == 8'hAA) begin
            m_synced = 1'b1; m_rxon = 1'b1;
          end
        end else if (m_rxon) begin
          if (rx_ferr) begin
            m_rxon = 1'b0; m_err = 1'b1; m_buf.delete();
          end else begin
            m_buf.push_back(rx_data);
            if (m_buf.size() == 4) begin
              m_word = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
              m_buf.delete();
              m_wpend = 1'b1;
              e_we = 1'b1;
              e_addr = 32'(m_words);
              e_wdata = m_word;
            end
          end
        end
      end
    end
  end

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          tx_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      check("imem_we", 32'(imem_we), 32'(e_we));
      if (e_we) begin
        check("imem_addr", 32'(imem_addr), e_addr);
        check("imem_wdata", imem_wdata, e_wdata);
      end
      check("tx_start", 32'(tx_start), 32'(e_tx_start));
      check("tx_data", 32'(tx_data), m_sent ? 32'h55 : 32'h0);
      check("word_count", 32'(word_count), 32'(m_words));
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_err", 32'(load_err), 32'(m_err));
      if (imem_we) begin
        wr_addr.push_back(32'(imem_addr));
        wr_data.push_back(imem_wdata);
      end
      if (tx_start) tx_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst imem_we", 32'(imem_we), 0);
    check("rst imem_addr", 32'(imem_addr), 0);
    check("rst imem_wdata", imem_wdata, 0);
    check("rst tx_start", 32'(tx_start), 0);
    check("rst tx_data", 32'(tx_data), 0);
    check("rst word_count", 32'(word_count), 0);
    check("rst load_done", 32'(load_done), 0);
    check("rst load_err", 32'(load_err), 0);
    rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr);
    @(negedge clk);
    rx_data = b;
    rx_ferr = ferr;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_ferr = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base, tbase;
  logic [31:0] prog[4];

  initial begin
    prog[0] = 32'h0000_0020; prog[1] = 32'h2008_000C;
    prog[2] = 32'hFC00_0000; prog[3] = 32'h0000_0000;

    // Three words plus terminator.
    do_reset();
    base = wr_addr.size(); tbase = tx_cnt;
    send_byte(8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) send_word(prog[i]);
    idle(6);
    check("prog writes", 32'(wr_addr.size() - base), 4);
    for (int i = 0; i < 4; i++) begin
      if (wr_addr.size() > base + i) begin
        check("prog addr", wr_addr[base + i], 32'(i));
        check("prog data", wr_data[base + i], prog[i]);
      end
    end
    check("prog tx pulses", 32'(tx_cnt - tbase), 1);
    check("prog tx_data", 32'(tx_data), 32'h55);
    check("prog done", 32'(load_done), 1);
    check("prog count", 32'(word_count), 4);

    // Garbage before sync.
    do_reset();
    base = wr_addr.size();
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'hAA, 1'b1);
    send_byte(8'hAA, 1'b0); send_word(32'h0);
    idle(6);
    check("garbage writes", 32'(wr_addr.size() - base), 1);
    if (wr_addr.size() > base) check("garbage addr", wr_addr[base], 0);
    check("garbage done", 32'(load_done), 1);

    // ACK backpressure.
    do_reset();
    tbase = tx_cnt;
    busy_force = 1'b1;
    send_byte(8'hAA, 1'b0); send_word(32'h0);
    idle(50);
    check("busy held tx", 32'(tx_cnt - tbase), 0);
    check("busy held done", 32'(load_done), 0);
    busy_force = 1'b0;
    idle(6);
    check("busy release tx", 32'(tx_cnt - tbase), 1);
    check("busy release done", 32'(load_done), 1);

    // Framing error on byte 2 of word 2.
    do_reset();
    base = wr_addr.size(); tbase = tx_cnt;
    send_byte(8'hAA, 1'b0); send_word(32'h1122_3344);
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b1);
    send_word(32'h7788_99AA); send_word(32'h0);
    idle(6);
    check("ferr writes", 32'(wr_addr.size() - base), 1);
    if (wr_addr.size() > base) check("ferr addr", wr_addr[base], 0);
    check("ferr err", 32'(load_err), 1);
    check("ferr tx", 32'(tx_cnt - tbase), 0);

    // Overflow: five nonzero words into four slots.
    do_reset();
    base = wr_addr.size(); tbase = tx_cnt;
    send_byte(8'hAA, 1'b0);
    for (int i = 1; i <= 5; i++) send_word(32'h0101_0101 * i);
    idle(6);
    check("ovf writes", 32'(wr_addr.size() - base), 4);
    if (wr_addr.size() > base + 3) check("ovf last addr", wr_addr[base + 3], 3);
    check("ovf err", 32'(load_err), 1);
    check("ovf count", 32'(word_count), 4);
    check("ovf tx", 32'(tx_cnt - tbase), 0);

    // Reset mid-word, then a clean load.
    do_reset();
    send_byte(8'hAA, 1'b0); send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    do_reset();
    base = wr_addr.size();
    send_byte(8'hAA, 1'b0); send_word(32'h0);
    idle(6);
    check("midrst writes", 32'(wr_addr.size() - base), 1);
    if (wr_addr.size() > base) check("midrst addr", wr_addr[base], 0);
    check("midrst done", 32'(load_done), 1);

    // Randomized loads; the per-cycle model does the checking.
    rand_busy = 1'b1;
    for (int it = 0; it < 25; it++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom), 1'($urandom_range(0, 3) == 0));
      send_byte(8'hAA, 1'b0);
      repeat ($urandom_range(0, 5)) begin
        for (int i = 0; i < 4; i++) begin
          send_byte((it % 3 == 0) ? 8'hAA : 8'($urandom), 1'($urandom_range(0, 40) == 0));
        end
      end
      send_word(32'h0);
      idle(20);
    end
    rand_busy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
